// File: rtl/if_buf_tx_pkg.sv
// Shared types for the input-feature-map buffer transmitter.
// Contents: transmitter FSM state enum and the pixel payload struct.
package if_buf_tx_pkg;

    localparam int unsigned PixDWd = 16;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_DRAIN,
        TX_DONE
    } IfTxState;

    // Pixel as presented to the PE input pad.
    typedef struct packed {
        logic [PixDWd-1:0] data;
        logic              zero;
    } pix_t;

endpackage

// File: rtl/if_buf_tx_if.sv
// Bundle of the buffer transmitter's control, fill and pixel-link signals.
// master: the transmitter (drives o_*), slave: its environment (drives i_*).
interface if_buf_tx_if #(
    parameter int unsigned DWd     = 16,
    parameter int unsigned ConfDWd = 4
) ();

    logic               i_start;
    logic [ConfDWd-1:0] i_len;
    logic [ConfDWd-1:0] i_rows;
    logic               i_wvalid;
    logic               o_wready;
    logic [DWd-1:0]     i_wdata;
    logic               o_valid;
    logic               i_ready;
    logic [DWd-1:0]     o_data;
    logic               o_zero;
    logic               o_row_last;
    logic               o_frame_last;
    logic               o_busy;
    logic               o_done;

    modport master (
        input  i_start, i_len, i_rows, i_wvalid, i_wdata, i_ready,
        output o_wready, o_valid, o_data, o_zero, o_row_last, o_frame_last,
               o_busy, o_done
    );

    modport slave (
        output i_start, i_len, i_rows, i_wvalid, i_wdata, i_ready,
        input  o_wready, o_valid, o_data, o_zero, o_row_last, o_frame_last,
               o_busy, o_done
    );

endinterface

// File: rtl/if_buf_tx_pix_fifo.sv
// pix_fifo: synchronous pixel FIFO, no bypass (a push is visible at head next cycle).
// Ports: clk, rst_n, push/wdata (ignored when full), pop (ignored when empty),
//        full, empty, head (data at read pointer).
module pix_fifo #(
    parameter int unsigned DWd    = 16,
    parameter int unsigned AddrWd = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic [DWd-1:0] wdata,
    input  logic           pop,
    output logic           full,
    output logic           empty,
    output logic [DWd-1:0] head
);

    localparam int unsigned Depth = 2 ** AddrWd;
    localparam int unsigned CntW  = AddrWd + 1;

    logic [DWd-1:0]    mem [Depth];
    logic [AddrWd-1:0] wr_ptr;
    logic [AddrWd-1:0] rd_ptr;
    logic [CntW-1:0]   count;
    logic              do_push;
    logic              do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally modulo the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AddrWd'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AddrWd'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; reset only clears the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_buf_tx.sv
// if_buf_tx: read-side transmitter of the input-feature-map buffer.
// Buffers upstream pixels in pix_fifo and, per start, streams len x rows pixels
// to the PE input pad with zero, row-last and frame-last markers.
// Ports: i_clk, i_rstn (async active-low), bus (if_buf_tx_if.master: start/config,
//        upstream fill handshake, pad valid/ready/data/zero/last, busy, done).
module if_buf_tx
    import if_buf_tx_pkg::*;
#(
    parameter int unsigned DWd     = 16,
    parameter int unsigned AddrWd  = 4,
    parameter int unsigned ConfDWd = 4
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    if_buf_tx_if.master   bus
);

    if (DWd != PixDWd) begin : g_dwd_check
        $error("if_buf_tx: DWd must match the package pixel width");
    end

    IfTxState           state_q, state_d;
    logic [ConfDWd-1:0] len_q, rows_q, pix_cnt_q, row_cnt_q;
    pix_t               pix_q;
    logic               valid_q, row_last_q, frame_last_q, busy_q, done_q;
    logic               busy_d, done_d;
    logic               fifo_full, fifo_empty;
    logic [DWd-1:0]     fifo_head;
    logic               load_c, xfer_c, start_c, cfg_zero_c, row_end_c, frame_end_c;

    pix_fifo #(.DWd(DWd), .AddrWd(AddrWd)) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .push  (bus.i_wvalid),
        .wdata (bus.i_wdata),
        .pop   (load_c),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign start_c     = (state_q == TX_IDLE) & bus.i_start;
    assign cfg_zero_c  = (bus.i_len == '0) | (bus.i_rows == '0);
    assign xfer_c      = valid_q & bus.i_ready;
    // Output register refills whenever it is empty or being drained this cycle.
    assign load_c      = (state_q == TX_SEND) & ~fifo_empty & (~valid_q | bus.i_ready);
    assign row_end_c   = (pix_cnt_q == len_q - ConfDWd'(1));
    assign frame_end_c = row_end_c & (row_cnt_q == rows_q - ConfDWd'(1));

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= TX_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state; busy/done are registered copies of the next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TX_IDLE:  if (start_c) state_d = cfg_zero_c ? TX_DONE : TX_SEND;
            TX_SEND:  if (load_c && frame_end_c) state_d = TX_DRAIN;
            TX_DRAIN: if (xfer_c) state_d = TX_DONE;
            TX_DONE:  state_d = TX_IDLE;
            default:  state_d = TX_IDLE;
        endcase
        busy_d = (state_d != TX_IDLE);
        done_d = (state_d == TX_DONE);
    end

    // Config latch, pixel/row counters and the pad output register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            len_q        <= '0;
            rows_q       <= '0;
            pix_cnt_q    <= '0;
            row_cnt_q    <= '0;
            pix_q        <= '0;
            valid_q      <= 1'b0;
            row_last_q   <= 1'b0;
            frame_last_q <= 1'b0;
        end else begin
            if (start_c) begin
                len_q     <= bus.i_len;
                rows_q    <= bus.i_rows;
                pix_cnt_q <= '0;
                row_cnt_q <= '0;
            end else if (load_c) begin
                if (row_end_c) begin
                    pix_cnt_q <= '0;
                    row_cnt_q <= row_cnt_q + ConfDWd'(1);
                end else begin
                    pix_cnt_q <= pix_cnt_q + ConfDWd'(1);
                end
            end
            if (load_c) begin
                valid_q      <= 1'b1;
                pix_q.data   <= fifo_head;
                pix_q.zero   <= (fifo_head == '0);
                row_last_q   <= row_end_c;
                frame_last_q <= frame_end_c;
            end else if (xfer_c) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_wready     = ~fifo_full;
    assign bus.o_valid      = valid_q;
    assign bus.o_data       = pix_q.data;
    assign bus.o_zero       = pix_q.zero;
    assign bus.o_row_last   = row_last_q;
    assign bus.o_frame_last = frame_last_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;

endmodule

// File: tb/tb_if_buf_tx.sv
// Self-checking bench for if_buf_tx: a directed table for the basic frame, hand
// sequences for stalls/gaps/full/len0/reset, and randomized traffic against a
// stream-level reference model (pixel queue plus per-frame beat index).
module tb_if_buf_tx;

    localparam int unsigned DWd     = 16;
    localparam int unsigned AddrWd  = 4;
    localparam int unsigned ConfDWd = 4;

    logic i_clk;
    logic i_rstn;

    if_buf_tx_if #(.DWd(DWd), .ConfDWd(ConfDWd)) bus ();

    if_buf_tx #(.DWd(DWd), .AddrWd(AddrWd), .ConfDWd(ConfDWd)) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .bus    (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 frame active, 2 done cycle.
    logic [DWd-1:0] mq [$];
    int phase    = 0;
    int m_len    = 0;
    int m_rows   = 0;
    int beat_idx = 0;
    int xfer_cnt = 0;
    logic           prev_hold = 1'b0;
    logic [DWd-1:0] prev_data;
    logic [2:0]     prev_flags;

    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rstn) begin
                mq.delete();
                phase     = 0;
                beat_idx  = 0;
                prev_hold = 1'b0;
                chk("rst_valid", 32'(bus.o_valid), 0);
                chk("rst_data", 32'(bus.o_data), 0);
                chk("rst_flags", 32'({bus.o_zero, bus.o_row_last, bus.o_frame_last}), 0);
                chk("rst_busy", 32'(bus.o_busy), 0);
                chk("rst_done", 32'(bus.o_done), 0);
                chk("rst_wready", 32'(bus.o_wready), 1);
            end else begin
                int np;
                np = phase;
                chk("done", 32'(bus.o_done), 32'(phase == 2));
                chk("busy", 32'(bus.o_busy), 32'(phase != 0));
                if (phase != 1) chk("valid_off", 32'(bus.o_valid), 0);
                if (prev_hold) begin
                    chk("hold_valid", 32'(bus.o_valid), 1);
                    chk("hold_data", 32'(bus.o_data), 32'(prev_data));
                    chk("hold_flags", 32'({bus.o_zero, bus.o_row_last, bus.o_frame_last}),
                        32'(prev_flags));
                end
                case (phase)
                    0: if (bus.i_start) begin
                        m_len    = int'(bus.i_len);
                        m_rows   = int'(bus.i_rows);
                        beat_idx = 0;
                        np = (m_len * m_rows == 0) ? 2 : 1;
                    end
                    1: if (bus.o_valid && bus.i_ready) begin
                        if (mq.size() == 0) begin
                            chk("xfer_no_pixel", 1, 0);
                        end else begin
                            logic [DWd-1:0] e;
                            e = mq.pop_front();
                            chk("beat_data", 32'(bus.o_data), 32'(e));
                            chk("beat_zero", 32'(bus.o_zero), 32'(e == '0));
                            chk("beat_row_last", 32'(bus.o_row_last),
                                32'((beat_idx % m_len) == m_len - 1));
                            chk("beat_frame_last", 32'(bus.o_frame_last),
                                32'(beat_idx == m_len * m_rows - 1));
                        end
                        xfer_cnt++;
                        beat_idx++;
                        if (beat_idx == m_len * m_rows) np = 2;
                    end
                    default: np = 0;
                endcase
                phase      = np;
                prev_hold  = bus.o_valid && !bus.i_ready;
                prev_data  = bus.o_data;
                prev_flags = {bus.o_zero, bus.o_row_last, bus.o_frame_last};
                if (bus.i_wvalid && bus.o_wready) mq.push_back(bus.i_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_px(input logic [DWd-1:0] d);
        bus.i_wvalid = 1'b1;
        bus.i_wdata  = d;
        tick();
        bus.i_wvalid = 1'b0;
    endtask

    task automatic start_frame(input int len, input int rows);
        bus.i_start = 1'b1;
        bus.i_len   = ConfDWd'(len);
        bus.i_rows  = ConfDWd'(rows);
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (phase != 0 && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({name, "_timeout"}, 1, 0);
    endtask

    typedef struct packed {
        logic           valid;
        logic [DWd-1:0] data;
        logic           zero;
        logic           rl;
        logic           fl;
        logic           done;
        logic           busy;
    } row_t;

    row_t tab [9];
    logic [DWd-1:0] fill6 [6];

    initial begin
        #500000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int n;
        tab[0] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[1] = '{1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[2] = '{1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[3] = '{1'b1, 16'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tab[4] = '{1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[5] = '{1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[6] = '{1'b1, 16'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tab[7] = '{1'b0, 16'd9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tab[8] = '{1'b0, 16'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        fill6[0] = 16'd5; fill6[1] = 16'd0; fill6[2] = 16'd7;
        fill6[3] = 16'd0; fill6[4] = 16'd0; fill6[5] = 16'd9;

        i_rstn       = 1'b0;
        bus.i_start  = 1'b0;
        bus.i_len    = '0;
        bus.i_rows   = '0;
        bus.i_wvalid = 1'b0;
        bus.i_wdata  = '0;
        bus.i_ready  = 1'b1;
        repeat (2) tick();
        i_rstn = 1'b1;
        tick();

        // Basic frame, table of per-cycle expectations from the start cycle on.
        for (int i = 0; i < 6; i++) push_px(fill6[i]);
        start_frame(3, 2);
        for (int k = 0; k < 9; k++) begin
            @(negedge i_clk);
            chk($sformatf("t1_valid[%0d]", k), 32'(bus.o_valid), 32'(tab[k].valid));
            chk($sformatf("t1_done[%0d]", k), 32'(bus.o_done), 32'(tab[k].done));
            chk($sformatf("t1_busy[%0d]", k), 32'(bus.o_busy), 32'(tab[k].busy));
            if (tab[k].valid) begin
                chk($sformatf("t1_data[%0d]", k), 32'(bus.o_data), 32'(tab[k].data));
                chk($sformatf("t1_flags[%0d]", k),
                    32'({bus.o_zero, bus.o_row_last, bus.o_frame_last}),
                    32'({tab[k].zero, tab[k].rl, tab[k].fl}));
            end
        end
        tick();

        // Same frame with the pad stalling in a 1,0,0,1 pattern.
        x0 = xfer_cnt;
        for (int i = 0; i < 6; i++) push_px(fill6[i]);
        start_frame(3, 2);
        n = 0;
        while (phase != 0 && n < 200) begin
            bus.i_ready = (n % 4 == 0) || (n % 4 == 3);
            tick();
            n++;
        end
        if (n >= 200) chk("t2_timeout", 1, 0);
        chk("t2_xfers", 32'(xfer_cnt - x0), 6);
        bus.i_ready = 1'b1;

        // Start on an empty FIFO, pixels trickle in every third cycle.
        x0 = xfer_cnt;
        start_frame(4, 1);
        repeat (3) tick();
        bus.i_wvalid = 1'b1;
        bus.i_wdata  = 16'h000a;
        tick();
        bus.i_wvalid = 1'b0;
        @(negedge i_clk);
        chk("fill_lat_t1", 32'(bus.o_valid), 0);
        @(negedge i_clk);
        chk("fill_lat_t2", 32'(bus.o_valid), 1);
        tick();
        for (int i = 1; i < 4; i++) begin
            repeat (2) tick();
            push_px(16'(10 + i));
        end
        wait_idle("t3", 50);
        chk("t3_xfers", 32'(xfer_cnt - x0), 4);

        // Fill to full with no start, then drain 2 and later the remaining 14.
        for (int i = 0; i < 16; i++) begin
            bus.i_wvalid = 1'b1;
            bus.i_wdata  = 16'(16'h0100 + i);
            if (i == 15) begin
                @(negedge i_clk);
                chk("wready_before_16th", 32'(bus.o_wready), 1);
            end
            tick();
        end
        bus.i_wdata = 16'hdead;
        @(negedge i_clk);
        chk("wready_full", 32'(bus.o_wready), 0);
        tick();
        bus.i_wvalid = 1'b0;
        x0 = xfer_cnt;
        start_frame(2, 1);
        wait_idle("t4a", 50);
        @(negedge i_clk);
        chk("wready_after_2", 32'(bus.o_wready), 1);
        tick();
        chk("t4a_xfers", 32'(xfer_cnt - x0), 2);
        start_frame(14, 1);
        wait_idle("t4b", 100);
        chk("t4b_xfers", 32'(xfer_cnt - x0), 16);
        start_frame(1, 1);
        repeat (5) tick();
        @(negedge i_clk);
        chk("t4_fifo_empty", 32'(bus.o_valid), 0);
        tick();
        push_px(16'h0033);
        wait_idle("t4c", 20);

        // Zero-length frame, then a start pulse during TX_SEND is ignored.
        start_frame(0, 3);
        @(negedge i_clk);
        chk("len0_done", 32'(bus.o_done), 1);
        chk("len0_valid", 32'(bus.o_valid), 0);
        tick();
        @(negedge i_clk);
        chk("len0_idle_busy", 32'(bus.o_busy), 0);
        tick();
        x0 = xfer_cnt;
        bus.i_ready = 1'b0;
        start_frame(2, 1);
        repeat (2) tick();
        start_frame(1, 1);
        push_px(16'h0041);
        push_px(16'h0042);
        repeat (3) tick();
        bus.i_ready = 1'b1;
        wait_idle("t5", 50);
        chk("t5_xfers", 32'(xfer_cnt - x0), 2);

        // Reset after 2 of 6 beats.
        x0 = xfer_cnt;
        for (int i = 0; i < 6; i++) push_px(16'(16'h0061 + i));
        start_frame(3, 2);
        n = 0;
        while (xfer_cnt - x0 < 2 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("t6_timeout", 1, 0);
        i_rstn = 1'b0;
        repeat (2) tick();
        i_rstn = 1'b1;
        repeat (10) tick();
        start_frame(1, 1);
        repeat (4) tick();
        @(negedge i_clk);
        chk("t6_fifo_flushed", 32'(bus.o_valid), 0);
        tick();
        push_px(16'h0007);
        wait_idle("t6", 20);

        // Randomized traffic, including occasional starts while busy.
        for (int c = 0; c < 1500; c++) begin
            bus.i_wvalid = 1'($urandom_range(0, 1));
            bus.i_wdata  = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
            bus.i_ready  = ($urandom_range(0, 3) != 0);
            bus.i_start  = 1'b0;
            if ((phase == 0 && $urandom_range(0, 5) == 0) || $urandom_range(0, 20) == 0) begin
                bus.i_start = 1'b1;
                bus.i_len   = ConfDWd'($urandom_range(0, 4));
                bus.i_rows  = ConfDWd'($urandom_range(0, 3));
            end
            tick();
        end
        bus.i_start = 1'b0;
        bus.i_ready = 1'b1;
        n = 0;
        while (phase != 0 && n < 1000) begin
            bus.i_wvalid = 1'($urandom_range(0, 1));
            bus.i_wdata  = 16'($urandom);
            tick();
            n++;
        end
        if (n >= 1000) chk("rand_timeout", 1, 0);
        bus.i_wvalid = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
